// File: rtl/instr_window_loader_pkg.sv
// Shared definitions for the instruction window loader: field layout, opcodes and FSM states.
package instr_window_loader_pkg;

   localparam int unsigned WINDOW   = 4;
   localparam int unsigned INSTR_W  = 8;
   localparam int unsigned FIELD_W  = 2;
   localparam int unsigned OPC_LSB  = 6;
   localparam int unsigned SRC1_LSB = 4;
   localparam int unsigned SRC2_LSB = 2;
   localparam int unsigned DEST_LSB = 0;

   typedef enum logic [1:0] {
      OP_ALU_A = 2'b00,
      OP_ALU_B = 2'b01,
      OP_MUL   = 2'b10,
      OP_DIV   = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [FIELD_W-1:0] instr_field(input logic [INSTR_W-1:0] instr,
                                                      input int unsigned lsb);
      return instr[lsb +: FIELD_W];
   endfunction

endpackage

// File: rtl/instr_window_loader_raw_matrix_gen.sv
// Combinational read-after-write matrix: bit [4k+j] set when younger slot j reads dest of older slot k.
module raw_matrix_gen
   import instr_window_loader_pkg::*;
(
   input  logic [WINDOW*INSTR_W-1:0] instr_flat,
   input  logic [WINDOW-1:0]         valid_bits,
   output logic [WINDOW*WINDOW-1:0]  raw_flat
);

   always_comb begin
      raw_flat = '0;
      for (int unsigned j = 1; j < WINDOW; j++) begin
         for (int unsigned k = 0; k < j; k++) begin
            if (valid_bits[k] && valid_bits[j] &&
                ((instr_field(instr_flat[j*INSTR_W +: INSTR_W], SRC1_LSB) ==
                  instr_field(instr_flat[k*INSTR_W +: INSTR_W], DEST_LSB)) ||
                 (instr_field(instr_flat[j*INSTR_W +: INSTR_W], SRC2_LSB) ==
                  instr_field(instr_flat[k*INSTR_W +: INSTR_W], DEST_LSB))))
               raw_flat[k*WINDOW + j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/instr_window_loader.sv
// Collects up to four instructions into a window, hands it to the scheduler and tracks retirement.
module instr_window_loader
   import instr_window_loader_pkg::*;
#(
   parameter int unsigned FILL_TIMEOUT = 8,
   parameter int unsigned WD_LIMIT     = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_instr,
   output logic        sch_clear,
   output logic        sch_enable,
   output logic [31:0] instr_flat,
   output logic [3:0]  valid_bits,
   output logic [15:0] raw_flat,
   input  logic [3:0]  issue_onehot,
   input  logic [3:0]  retire_onehot,
   output logic        window_done,
   output logic [15:0] window_count,
   output logic        err_stuck,
   output logic        err_protocol
);

   localparam logic [15:0] IDLE_LAST = 16'(FILL_TIMEOUT - 1);
   localparam logic [15:0] RUN_LAST  = 16'(WD_LIMIT - 1);
   localparam logic [2:0]  LAST_SLOT = 3'(WINDOW - 1);

   state_t      state;
   logic [2:0]  fill_cnt;
   logic [15:0] idle_cnt;
   logic [15:0] run_cnt;
   logic [3:0]  issued;

   logic        accept;
   logic        fill_full;
   logic        fill_timeout;
   logic [31:0] fill_instr;
   logic [3:0]  fill_valid;
   logic [15:0] raw_next;
   logic [3:0]  retire_ok;
   logic [3:0]  retire_bad;

   // raw_flat is captured on the FILL exit edge, so the matrix is built from the post-accept slots
   always_comb begin
      accept     = (state == ST_FILL) && in_ready && in_valid;
      fill_instr = instr_flat;
      fill_valid = valid_bits;
      if (accept) begin
         fill_instr[{fill_cnt[1:0], 3'b000} +: 8] = in_instr;
         fill_valid[fill_cnt[1:0]]                 = 1'b1;
      end
      fill_full    = accept && (fill_cnt == LAST_SLOT);
      fill_timeout = (state == ST_FILL) && !in_valid && (fill_cnt != 3'd0) &&
                     (idle_cnt == IDLE_LAST);
      retire_ok    = retire_onehot & valid_bits & (issued | issue_onehot);
      retire_bad   = retire_onehot & ~retire_ok;
   end

   raw_matrix_gen u_raw (
      .instr_flat (fill_instr),
      .valid_bits (fill_valid),
      .raw_flat   (raw_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_FILL;
         in_ready     <= 1'b1;
         sch_clear    <= 1'b0;
         sch_enable   <= 1'b0;
         instr_flat   <= '0;
         valid_bits   <= '0;
         raw_flat     <= '0;
         window_done  <= 1'b0;
         window_count <= '0;
         err_stuck    <= 1'b0;
         err_protocol <= 1'b0;
         fill_cnt     <= '0;
         idle_cnt     <= '0;
         run_cnt      <= '0;
         issued       <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (accept) begin
                  instr_flat <= fill_instr;
                  valid_bits <= fill_valid;
                  fill_cnt   <= fill_cnt + 3'd1;
                  idle_cnt   <= '0;
               end else if (fill_cnt != 3'd0) begin
                  idle_cnt <= idle_cnt + 16'd1;
               end
               if (fill_full || fill_timeout) begin
                  state     <= ST_CLEAR;
                  raw_flat  <= raw_next;
                  in_ready  <= 1'b0;
                  sch_clear <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state      <= ST_RUN;
               sch_clear  <= 1'b0;
               sch_enable <= 1'b1;
               run_cnt    <= '0;
            end
            ST_RUN: begin
               issued     <= issued | (issue_onehot & valid_bits);
               valid_bits <= valid_bits & ~retire_ok;
               run_cnt    <= run_cnt + 16'd1;
               if (retire_bad != 4'd0)
                  err_protocol <= 1'b1;
               if ((valid_bits == 4'd0) || (run_cnt == RUN_LAST)) begin
                  state        <= ST_DONE;
                  sch_enable   <= 1'b0;
                  window_done  <= 1'b1;
                  window_count <= window_count + 16'd1;
                  if (valid_bits != 4'd0)
                     err_stuck <= 1'b1;
               end
            end
            ST_DONE: begin
               state       <= ST_FILL;
               window_done <= 1'b0;
               in_ready    <= 1'b1;
               instr_flat  <= '0;
               valid_bits  <= '0;
               raw_flat    <= '0;
               issued      <= '0;
               fill_cnt    <= '0;
               idle_cnt    <= '0;
               run_cnt     <= '0;
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_window_loader.sv
// Self-checking bench for instr_window_loader: vector table, directed corner cases and random windows.
module tb_instr_window_loader;

   localparam int FT = 8;
   localparam int WD = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_instr;
   logic        sch_clear;
   logic        sch_enable;
   logic [31:0] instr_flat;
   logic [3:0]  valid_bits;
   logic [15:0] raw_flat;
   logic [3:0]  issue_onehot;
   logic [3:0]  retire_onehot;
   logic        window_done;
   logic [15:0] window_count;
   logic        err_stuck;
   logic        err_protocol;

   int   checks   = 0;
   int   failures = 0;
   int   exp_wc   = 0;
   logic exp_errp = 1'b0;
   logic exp_errs = 1'b0;

   typedef struct {
      logic [31:0] ins;
      int          n;
      logic [15:0] raw;
   } vec_t;
   vec_t tbl[6];

   instr_window_loader #(.FILL_TIMEOUT(FT), .WD_LIMIT(WD)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .sch_clear     (sch_clear),
      .sch_enable    (sch_enable),
      .instr_flat    (instr_flat),
      .valid_bits    (valid_bits),
      .raw_flat      (raw_flat),
      .issue_onehot  (issue_onehot),
      .retire_onehot (retire_onehot),
      .window_done   (window_done),
      .window_count  (window_count),
      .err_stuck     (err_stuck),
      .err_protocol  (err_protocol)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_raw(input logic [31:0] ins, input int n);
      logic [15:0] r = '0;
      for (int j = 0; j < n; j++)
         for (int k = 0; k < j; k++)
            if (ins[8*j+4 +: 2] == ins[8*k +: 2] || ins[8*j+2 +: 2] == ins[8*k +: 2])
               r[4*k+j] = 1'b1;
      return r;
   endfunction

   // Leaves the bench observing the first RUN cycle of the new window.
   task automatic fill_window(input logic [31:0] ins, input int n, input logic [15:0] raw_exp,
                              input int max_gap);
      int          gap;
      int          cnt;
      logic [31:0] mask;
      for (int k = 0; k < n; k++) begin
         gap = (max_gap == 0) ? 0 : ((k == 0) ? $urandom_range(0, 12) : $urandom_range(0, max_gap));
         repeat (gap) begin
            in_valid      = 1'b0;
            issue_onehot  = 4'($urandom);
            retire_onehot = 4'($urandom);
            tick();
         end
         chk("in_ready_fill", 32'(in_ready), 1);
         in_valid      = 1'b1;
         in_instr      = ins[8*k +: 8];
         issue_onehot  = 4'($urandom);
         retire_onehot = 4'($urandom);
         tick();
         in_valid      = 1'b0;
         issue_onehot  = 4'd0;
         retire_onehot = 4'd0;
      end
      if (n == 4) begin
         chk("clear_after_full", 32'(sch_clear), 1);
      end else begin
         cnt = 0;
         while (sch_clear !== 1'b1 && cnt < 3*FT) begin
            tick();
            cnt++;
         end
         chk("fill_timeout_cycles", 32'(cnt), FT);
      end
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
      chk("raw_flat", 32'(raw_flat), 32'(raw_exp));
      chk("valid_bits_fill", 32'(valid_bits), (32'd1 << n) - 32'd1);
      chk("instr_flat", instr_flat, ins & mask);
      chk("clear_in_ready", 32'(in_ready), 0);
      chk("clear_sch_enable", 32'(sch_enable), 0);
      in_valid = 1'b1;
      in_instr = 8'hAA;
      tick();
      in_valid = 1'b0;
      chk("run_sch_enable", 32'(sch_enable), 1);
      chk("run_sch_clear", 32'(sch_clear), 0);
      chk("run_instr_flat", instr_flat, ins & mask);
   endtask

   // Same-cycle issue+retire of each slot in ascending order, then the close-out sequence.
   task automatic drain(input int n);
      logic [3:0] remain = 4'((1 << n) - 1);
      for (int b = 0; b < n; b++) begin
         issue_onehot  = 4'(1 << b);
         retire_onehot = 4'(1 << b);
         tick();
         issue_onehot  = 4'd0;
         retire_onehot = 4'd0;
         remain[b]     = 1'b0;
         chk("drain_valid", 32'(valid_bits), 32'(remain));
      end
      chk("done_not_early", 32'(window_done), 0);
      tick();
      exp_wc++;
      chk("window_done", 32'(window_done), 1);
      chk("window_count", 32'(window_count), 32'(exp_wc[15:0]));
      chk("err_protocol", 32'(err_protocol), 32'(exp_errp));
      tick();
      chk("done_pulse_end", 32'(window_done), 0);
      chk("refill_ready", 32'(in_ready), 1);
      chk("refill_valid", 32'(valid_bits), 0);
   endtask

   task automatic random_window();
      int          n    = $urandom_range(1, 4);
      logic [31:0] ins  = $urandom;
      logic [3:0]  mval = 4'((1 << n) - 1);
      logic [3:0]  miss = 4'd0;
      logic [3:0]  iss, ret, bad;
      int          runs = 0;
      fill_window(ins, n, model_raw(ins, n), 7);
      for (int c = 0; c <= WD; c++) begin
         if (mval == 4'd0) begin
            tick();
            chk("rand_done_empty", 32'(window_done), 1);
            break;
         end
         iss  = 4'($urandom);
         ret  = 4'($urandom & $urandom);
         bad  = ret & ~(mval & (miss | iss));
         if (bad != 4'd0) exp_errp = 1'b1;
         mval = mval & ~(ret & ~bad);
         miss = miss | iss;
         issue_onehot  = iss;
         retire_onehot = ret;
         in_valid      = 1'($urandom);
         tick();
         issue_onehot  = 4'd0;
         retire_onehot = 4'd0;
         in_valid      = 1'b0;
         runs++;
         if (runs == WD) begin
            exp_errs = 1'b1;
            chk("rand_done_wd", 32'(window_done), 1);
            break;
         end
         chk("rand_valid", 32'(valid_bits), 32'(mval));
         chk("rand_err_protocol", 32'(err_protocol), 32'(exp_errp));
         chk("rand_ready_low", 32'(in_ready), 0);
      end
      exp_wc++;
      chk("rand_window_count", 32'(window_count), 32'(exp_wc[15:0]));
      chk("rand_err_stuck", 32'(err_stuck), 32'(exp_errs));
      tick();
      chk("rand_refill_ready", 32'(in_ready), 1);
   endtask

   initial begin
      int runs;
      tbl[0] = '{ins: 32'h0143_0201, n: 4, raw: 16'h0000};
      tbl[1] = '{ins: 32'h0403_1201, n: 4, raw: 16'h000A};
      tbl[2] = '{ins: 32'h7423_D681, n: 4, raw: 16'h084A};
      tbl[3] = '{ins: 32'h0000_0401, n: 2, raw: 16'h0002};
      tbl[4] = '{ins: 32'h008D_3C03, n: 3, raw: 16'h0046};
      tbl[5] = '{ins: 32'h0000_00FF, n: 1, raw: 16'h0000};

      reset         = 1'b1;
      in_valid      = 1'b0;
      in_instr      = 8'd0;
      issue_onehot  = 4'd0;
      retire_onehot = 4'd0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sch_clear", 32'(sch_clear), 0);
      chk("rst_sch_enable", 32'(sch_enable), 0);
      chk("rst_instr_flat", instr_flat, 0);
      chk("rst_raw_flat", 32'(raw_flat), 0);
      chk("rst_window_count", 32'(window_count), 0);
      chk("rst_errors", 32'({err_stuck, err_protocol}), 0);
      reset = 1'b0;
      repeat (FT + 4) tick();
      chk("empty_no_timeout", 32'(in_ready), 1);

      for (int t = 0; t < 6; t++) begin
         fill_window(tbl[t].ins, tbl[t].n, tbl[t].raw, (t % 2) * 7);
         drain(tbl[t].n);
      end

      fill_window(tbl[0].ins, 4, tbl[0].raw, 0);
      retire_onehot = 4'b0100;
      tick();
      retire_onehot = 4'd0;
      exp_errp = 1'b1;
      chk("proto_err", 32'(err_protocol), 1);
      chk("proto_valid_kept", 32'(valid_bits), 32'hF);
      drain(4);

      fill_window(tbl[5].ins, 1, tbl[5].raw, 0);
      runs = 0;
      while (window_done !== 1'b1 && runs < 3*WD) begin
         if (sch_enable === 1'b1) runs++;
         tick();
      end
      exp_wc++;
      exp_errs = 1'b1;
      chk("wd_run_cycles", 32'(runs), WD);
      chk("wd_err_stuck", 32'(err_stuck), 1);
      chk("wd_window_count", 32'(window_count), 32'(exp_wc[15:0]));
      tick();
      chk("wd_cleared_valid", 32'(valid_bits), 0);

      for (int r = 0; r < 30; r++) random_window();

      fill_window(tbl[2].ins, 4, tbl[2].raw, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_in_ready", 32'(in_ready), 1);
      chk("arst_sch", 32'({sch_clear, sch_enable}), 0);
      chk("arst_instr_flat", instr_flat, 0);
      chk("arst_valid_raw", 32'({valid_bits, raw_flat}), 0);
      chk("arst_window_count", 32'(window_count), 0);
      chk("arst_errors", 32'({err_stuck, err_protocol}), 0);
      chk("arst_no_done", 32'(window_done), 0);
      tick();
      chk("arst_no_done_edge", 32'(window_done), 0);
      reset    = 1'b0;
      exp_wc   = 0;
      exp_errp = 1'b0;
      exp_errs = 1'b0;
      fill_window(tbl[1].ins, 4, tbl[1].raw, 0);
      drain(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/instr_window_loader.md
INSTR_WINDOW_LOADER -- requirements
Module: instr_window_loader

Interface
REQ-001 Parameter FILL_TIMEOUT, default 8: idle input cycles before a partial window launches.
REQ-002 Parameter WD_LIMIT, default 64: RUN cycles before the window is force-closed.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  loader can accept an instruction (high only in FILL with a free slot).
REQ-007 in_instr  input  8  instruction: [7:6] opcode, [5:4] src1, [3:2] src2, [1:0] dest.
REQ-008 sch_clear  output  1  one-cycle synchronous reset pulse to the scheduler before each window.
REQ-009 sch_enable  output  1  scheduler enable; high only in RUN.
REQ-010 instr_flat  output  32  slot k at bits [8k+7:8k]; registered.
REQ-011 valid_bits  output  4  slot occupied and not yet retired.
REQ-012 raw_flat  output  16  bit [4k+j] set means slot j reads dest of older slot k (k<j).
REQ-013 issue_onehot  input  4  scheduler issue strobe.
REQ-014 retire_onehot  input  4  scheduler completion strobe.
REQ-015 window_done  output  1  one-cycle pulse when a window closes.
REQ-016 window_count  output  16  count of closed windows; wraps at 2^16.
REQ-017 err_stuck, err_protocol  output  1 each  sticky error flags.

Function
REQ-018 States: FILL, CLEAR, RUN, DONE; reset state FILL.
REQ-019 FILL: on in_valid && in_ready, write in_instr to the lowest free slot (0..3, in arrival order) and set its valid bit.
REQ-020 FILL -> CLEAR when 4 slots are filled, or when at least 1 slot is filled and in_valid has been low for FILL_TIMEOUT consecutive cycles; the idle counter clears on any accept.
REQ-021 Zero slots filled: remain in FILL indefinitely; no timeout.
REQ-022 On FILL exit, register raw_flat: bit [4k+j] = valid[k] && valid[j] && k<j && (src1[j]==dest[k] || src2[j]==dest[k]); all other bits 0, including diagonal and k>=j.
REQ-023 CLEAR lasts exactly 1 cycle with sch_clear=1 and sch_enable=0; then RUN.
REQ-024 RUN: sch_enable=1; instr_flat and raw_flat remain constant.
REQ-025 RUN: issue_onehot bit i sets issued[i]; retire_onehot bit i clears valid_bits[i] on the next edge.
REQ-026 Retire on a slot with valid=0 or issued=0 sets err_protocol and the event is otherwise ignored.
REQ-027 Issue and retire of the same slot in the same cycle are accepted (issued and retired).
REQ-028 RUN -> DONE when valid_bits==0 (registered value).
REQ-029 RUN -> DONE when the RUN cycle counter reaches WD_LIMIT; this also sets err_stuck.
REQ-030 DONE lasts 1 cycle: window_done=1, window_count+1, all slots, issued and valid_bits cleared; then FILL.
REQ-031 in_ready=0 in CLEAR, RUN and DONE; sch_enable=0 outside RUN; retire/issue strobes outside RUN are ignored without error.

Reset
REQ-032 Reset clears: state=FILL, in_ready=1, sch_clear=0, sch_enable=0, instr_flat=0, valid_bits=0, raw_flat=0, window_done=0, window_count=0, err_stuck=0, err_protocol=0, all counters=0.
REQ-033 Reset mid-window discards the window with no window_done pulse; the error flags clear only on reset.

Structure
REQ-034 Shared package holds the opcode encodings (ALU 00/01, MUL 10, DIV 11), instruction field positions, WINDOW=4, and state encodings.
REQ-035 One sub-module, raw_matrix_gen: combinational 4x4 RAW matrix from the slot contents and valid bits.
REQ-036 No other sub-modules; the FSM, counters and slot registers stay in the top.

Verification
REQ-037 Four independent ALU instructions back-to-back -> CLEAR at 4th accept+1, raw_flat=0x0000, retire 1,2,4,8 -> window_done one cycle after last retire, window_count=1.
REQ-038 Slot0 dest=01, slot1 src1=01, slot3 src2=01 -> raw_flat=0x000A (bits 1 and 3).
REQ-039 Two instructions then in_valid low -> CLEAR exactly FILL_TIMEOUT(8) cycles after the last accept, valid_bits=0011.
REQ-040 RUN with no retires -> DONE after 64 cycles, err_stuck=1, window_done pulses.
REQ-041 retire_onehot=0100 before any issue of slot 2 -> err_protocol=1, valid_bits unchanged.
REQ-042 Assert reset during RUN -> all outputs at reset values asynchronously, no window_done, next window starts in FILL.
